// File: rtl/acs_traceback_if.sv
// Symbol-side bus of the Viterbi traceback unit: ACS survivor decisions in,
// decided quaternary symbols and status out.
interface acs_traceback_if #(
    parameter int NUM_STATES = 16,
    parameter int SW         = 4
);
    logic                    symEn;
    logic [2*NUM_STATES-1:0] selIn;
    logic [SW-1:0]           bestState;
    logic [1:0]              decision;
    logic                    decisionEn;
    logic                    busy;
    logic                    overrun;

    modport master (
        output symEn, selIn, bestState,
        input  decision, decisionEn, busy, overrun
    );

    modport slave (
        input  symEn, selIn, bestState,
        output decision, decisionEn, busy, overrun
    );
endinterface

// File: rtl/acs_traceback.sv
// Viterbi survivor-path traceback: stores one row of ACS decisions per symbol
// and walks the trellis back TB_LEN steps from the best state to release a symbol.
module acs_traceback #(
    parameter int NUM_STATES = 16,
    parameter int SW         = 4,
    parameter int TB_LEN     = 16,
    parameter int PTR_BITS   = 5
) (
    input  logic           clk,
    input  logic           reset,
    acs_traceback_if.slave bus
);
    localparam int ROW_W = 2 * NUM_STATES;
    localparam int DEPTH = 2 ** PTR_BITS;
    localparam int CW    = $clog2(TB_LEN + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(TB_LEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(TB_LEN - 1);

    typedef enum logic {IDLE, TRACE} fsmState_t;

    fsmState_t           state, stateNext;
    logic [ROW_W-1:0]    buffer [DEPTH];
    logic [PTR_BITS-1:0] wrPtr, rdPtr;
    logic [CW-1:0]       fillCnt, fillNext, stepCnt;
    logic [SW-1:0]       trState;
    logic [ROW_W-1:0]    rdRow;
    logic [SW:0]         selIdx;
    logic [1:0]          sel;
    logic [1:0]          decisionReg;
    logic                decisionEnReg, overrunReg;
    logic                loadTrace, stepTrace, fireDecision, abortTrace;

    // NOTE: the survivor buffer has no reset; fillCnt gating keeps stale rows out of any decision.
    always_ff @(posedge clk) begin
        if (bus.symEn) buffer[wrPtr] <= bus.selIn;
    end

    assign rdRow    = buffer[rdPtr];
    assign selIdx   = {trState, 1'b0};
    assign sel      = rdRow[selIdx +: 2];
    assign fillNext = (fillCnt == FULL_CNT) ? FULL_CNT : fillCnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // A symbol landing on the final step lets the decision out before restarting.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        stateNext    = state;
        loadTrace    = 1'b0;
        stepTrace    = 1'b0;
        fireDecision = 1'b0;
        abortTrace   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.symEn && (fillNext == FULL_CNT)) begin
                    stateNext = TRACE;
                    loadTrace = 1'b1;
                end
            end
            TRACE: begin
                if (stepCnt == LAST_STEP) begin
                    fireDecision = 1'b1;
                    if (bus.symEn) loadTrace = 1'b1;
                    else           stateNext = IDLE;
                end else if (bus.symEn) begin
                    abortTrace = 1'b1;
                    loadTrace  = 1'b1;
                end else begin
                    stepTrace = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            fillCnt       <= '0;
            stepCnt       <= '0;
            trState       <= '0;
            decisionReg   <= '0;
            decisionEnReg <= 1'b0;
            overrunReg    <= 1'b0;
        end else begin
            decisionEnReg <= fireDecision;
            if (fireDecision) decisionReg <= sel;
            if (abortTrace)   overrunReg  <= 1'b1;
            if (bus.symEn) begin
                wrPtr   <= wrPtr + 1'b1;
                fillCnt <= fillNext;
            end
            if (loadTrace) begin
                trState <= bus.bestState;
                rdPtr   <= wrPtr;
                stepCnt <= '0;
            end else if (stepTrace) begin
                trState <= SW'({trState, sel});
                rdPtr   <= rdPtr - 1'b1;
                stepCnt <= stepCnt + 1'b1;
            end
        end
    end

    assign bus.decision   = decisionReg;
    assign bus.decisionEn = decisionEnReg;
    assign bus.busy       = (state == TRACE);
    assign bus.overrun    = overrunReg;
endmodule
